// File: rtl/sc_dot_product_engine_if.sv
// Handshake and operand bundle for the stochastic dot-product engine.
// The slave side is the engine; the master side is the producer/consumer.
interface sc_dot_product_engine_if #(
  parameter int DIMENSION = 4,
  parameter int WIDTH     = 8
);
  localparam int SEL_BITS = $clog2(DIMENSION);
  localparam int RES_BITS = 2*WIDTH + SEL_BITS + 1;

  logic                       in_valid;
  logic                       in_ready;
  logic [WIDTH*DIMENSION-1:0] datas;
  logic [WIDTH*DIMENSION-1:0] weights;
  logic [WIDTH-1:0]           seed_data;
  logic [WIDTH-1:0]           seed_weight;
  logic                       abort;
  logic                       busy;
  logic                       out_valid;
  logic                       out_ready;
  logic [WIDTH:0]             ones_count;
  logic [RES_BITS-1:0]        result;

  modport slave (
    input  in_valid, datas, weights, seed_data, seed_weight, abort, out_ready,
    output in_ready, busy, out_valid, ones_count, result
  );

  modport master (
    output in_valid, datas, weights, seed_data, seed_weight, abort, out_ready,
    input  in_ready, busy, out_valid, ones_count, result
  );
endinterface

// File: rtl/sc_dot_product_engine.sv
// Stochastic-computing dot-product engine: LFSR-driven SNGs, AND multiply,
// round-robin mux scaled add over a 2^WIDTH-cycle unipolar stream.
module sc_dot_product_engine #(
  parameter int DIMENSION = 4,
  parameter int WIDTH     = 8
) (
  input logic                    clk,
  input logic                    rst,
  sc_dot_product_engine_if.slave bus
);
  localparam int SEL_BITS = $clog2(DIMENSION);
  localparam int RES_BITS = 2*WIDTH + SEL_BITS + 1;

  // Maximal-length Fibonacci tap masks (bit n-1 set for tap n), widths 2..16.
  function automatic logic [31:0] lfsr_taps(input int w);
    case (w)
      2:       return 32'h0003;
      3:       return 32'h0006;
      4:       return 32'h000C;
      5:       return 32'h0014;
      6:       return 32'h0030;
      7:       return 32'h0060;
      8:       return 32'h00B8;
      9:       return 32'h0110;
      10:      return 32'h0240;
      11:      return 32'h0500;
      12:      return 32'h0829;
      13:      return 32'h100D;
      14:      return 32'h2015;
      15:      return 32'h6000;
      16:      return 32'hD008;
      default: return 32'h0000;
    endcase
  endfunction

  localparam logic [WIDTH-1:0] TAPS = WIDTH'(lfsr_taps(WIDTH));

  function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] v);
    return {v[WIDTH-2:0], ^(v & TAPS)};
  endfunction

  function automatic logic [WIDTH-1:0] nonzero_seed(input logic [WIDTH-1:0] s);
    return (s == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : s;
  endfunction

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t                     state, state_nxt;
  logic [WIDTH*DIMENSION-1:0] datas_q, weights_q;
  logic [WIDTH-1:0]           seed_data_q, seed_weight_q;
  logic [WIDTH-1:0]           lfsr_data, lfsr_weight;
  logic [WIDTH-1:0]           k_cnt;
  logic [WIDTH:0]             acc, acc_nxt;
  logic [WIDTH:0]             ones_q;
  logic [RES_BITS-1:0]        result_q;
  logic [DIMENSION-1:0]       prod;
  logic                       last;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.in_valid) state_nxt = LOAD;
      LOAD: state_nxt = bus.abort ? IDLE : RUN;
      RUN: begin
        if (bus.abort)  state_nxt = IDLE;
        else if (last)  state_nxt = DONE;
      end
      DONE: if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.in_ready   = (state == IDLE);
  assign bus.busy       = (state == LOAD) || (state == RUN);
  assign bus.out_valid  = (state == DONE);
  assign bus.ones_count = ones_q;
  assign bus.result     = result_q;

  // Operand capture only happens on the accepting edge, so no reset is needed.
  always_ff @(posedge clk) begin
    if (state == IDLE && bus.in_valid) begin
      datas_q       <= bus.datas;
      weights_q     <= bus.weights;
      seed_data_q   <= bus.seed_data;
      seed_weight_q <= bus.seed_weight;
    end
  end

  always_comb begin
    prod = '0;
    for (int d = 0; d < DIMENSION; d++) begin
      prod[d] = (datas_q[d*WIDTH +: WIDTH] >= lfsr_data) &&
                (weights_q[d*WIDTH +: WIDTH] >= lfsr_weight);
    end
  end

  // The stream position k doubles as the adder select: sel = k mod DIMENSION.
  assign last    = &k_cnt;
  assign acc_nxt = acc + (WIDTH+1)'(prod[k_cnt[SEL_BITS-1:0]]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr_data   <= '0;
      lfsr_weight <= '0;
      k_cnt       <= '0;
      acc         <= '0;
      ones_q      <= '0;
      result_q    <= '0;
    end else begin
      case (state)
        LOAD: begin
          lfsr_data   <= nonzero_seed(seed_data_q);
          lfsr_weight <= nonzero_seed(seed_weight_q);
          k_cnt       <= '0;
          acc         <= '0;
        end
        RUN: begin
          if (!bus.abort) begin
            lfsr_data   <= lfsr_step(lfsr_data);
            lfsr_weight <= lfsr_step(lfsr_weight);
            k_cnt       <= k_cnt + WIDTH'(1);
            acc         <= acc_nxt;
            if (last) begin
              ones_q   <= acc_nxt;
              result_q <= {acc_nxt, {(SEL_BITS+WIDTH){1'b0}}};
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_sc_dot_product_engine.sv
// Directed bench for sc_dot_product_engine (DIMENSION=4, WIDTH=8) with a
// stream-level reference model and a per-cycle output comparator.
module tb_sc_dot_product_engine;
  localparam int DIM = 4;
  localparam int W   = 8;
  localparam int L   = 256;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sc_dot_product_engine_if #(.DIMENSION(DIM), .WIDTH(W)) bus ();

  sc_dot_product_engine #(.DIMENSION(DIM), .WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   checks     = 0;
  int   errors     = 0;
  logic expect_out = 1'b0;
  int   exp_ones   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Reference: maximal 8-bit sequence x^8+x^6+x^5+x^4+1, shifted in at bit 0.
  function automatic int rng_next(input int x);
    int fb;
    fb = ((x >> 7) ^ (x >> 5) ^ (x >> 4) ^ (x >> 3)) & 1;
    return ((x << 1) & 255) | fb;
  endfunction

  function automatic int model_ones(input logic [31:0] d, input logic [31:0] w,
                                    input int sd, input int sw);
    int rd, rw, cnt, sel, dv, wv;
    rd  = (sd == 0) ? 1 : sd;
    rw  = (sw == 0) ? 1 : sw;
    cnt = 0;
    for (int k = 0; k < L; k++) begin
      sel = k % DIM;
      dv  = int'(d[sel*8 +: 8]);
      wv  = int'(w[sel*8 +: 8]);
      if (dv >= rd && wv >= rw) cnt++;
      rd = rng_next(rd);
      rw = rng_next(rw);
    end
    return cnt;
  endfunction

  // Whenever a result is presented it must be the model's value.
  always @(negedge clk) begin
    if (rst === 1'b1 && bus.out_valid === 1'b1) begin
      check("out_valid_expected", bus.out_valid, expect_out);
      if (expect_out) begin
        check("ones_count", bus.ones_count, exp_ones);
        check("result", bus.result, exp_ones * 1024);
      end
    end
  end

  task automatic submit(input logic [31:0] d, input logic [31:0] w,
                        input logic [7:0] sd, input logic [7:0] sw);
    int n;
    n = 0;
    @(negedge clk);
    while (bus.in_ready !== 1'b1 && n < 600) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_before_submit", bus.in_ready, 1);
    bus.datas       = d;
    bus.weights     = w;
    bus.seed_data   = sd;
    bus.seed_weight = sw;
    bus.in_valid    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("busy_after_accept", bus.busy, 1);
    check("in_ready_after_accept", bus.in_ready, 0);
  endtask

  task automatic run_job(input logic [31:0] d, input logic [31:0] w,
                         input logic [7:0] sd, input logic [7:0] sw, input int hold);
    int lat;
    exp_ones   = model_ones(d, w, int'(sd), int'(sw));
    expect_out = 1'b1;
    submit(d, w, sd, sw);
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (bus.out_valid !== 1'b1 && lat < 400);
    check("latency_edges", lat, L + 1);
    // Stall the consumer while offering a different job that must be ignored.
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'b1;
      bus.datas    = 32'h0;
      @(negedge clk);
      check("in_ready_in_done", bus.in_ready, 0);
      check("out_valid_held", bus.out_valid, 1);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("out_valid_after_accept", bus.out_valid, 0);
    check("in_ready_after_accept_out", bus.in_ready, 1);
    expect_out = 1'b0;
  endtask

  initial begin
    int prev;
    bus.in_valid    = 1'b0;
    bus.out_ready   = 1'b0;
    bus.abort       = 1'b0;
    bus.datas       = '0;
    bus.weights     = '0;
    bus.seed_data   = '0;
    bus.seed_weight = '0;

    repeat (3) @(negedge clk);
    check("reset_in_ready", bus.in_ready, 1);
    check("reset_busy", bus.busy, 0);
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_ones_count", bus.ones_count, 0);
    check("reset_result", bus.result, 0);
    rst = 1'b1;

    // Hand-computed pins for the model.
    check("model_all_zero_data", model_ones(32'h0, 32'h5A3C_7F11, 'hF3, 'h31), 0);
    check("model_all_ones", model_ones(32'hFFFF_FFFF, 32'hFFFF_FFFF, 'hF3, 'h31), 256);
    check("model_half", model_ones(32'h00FF_00FF, 32'hFFFF_FFFF, 'hF3, 'h31), 128);
    check("model_three_quarter", model_ones(32'hFFFF_FFFF, 32'h00FF_FFFF, 'hF3, 'h31), 192);
    check("model_small_in_range",
          (model_ones(32'h0F0F_0F0F, 32'h0A0A_0A0A, 'hF3, 'h31) <= 4), 1);
    check("model_seed0_eq_seed1",
          model_ones(32'h0F0F_0F0F, 32'h0A0A_0A0A, 'h00, 'h31),
          model_ones(32'h0F0F_0F0F, 32'h0A0A_0A0A, 'h01, 'h31));

    run_job(32'h0000_0000, 32'h5A3C_7F11, 8'hF3, 8'h31, 0);
    run_job(32'hFFFF_FFFF, 32'hFFFF_FFFF, 8'hF3, 8'h31, 0);
    run_job(32'h00FF_00FF, 32'hFFFF_FFFF, 8'hF3, 8'h31, 0);
    run_job(32'hFFFF_FFFF, 32'h00FF_FFFF, 8'hF3, 8'h31, 0);
    run_job(32'h0F0F_0F0F, 32'h0A0A_0A0A, 8'hF3, 8'h31, 0);
    run_job(32'h0F0F_0F0F, 32'h0A0A_0A0A, 8'h00, 8'h31, 0);
    run_job(32'h0F0F_0F0F, 32'h0A0A_0A0A, 8'h01, 8'h31, 0);
    run_job(32'h80C0_40FF, 32'hFF20_E0A0, 8'h5A, 8'h5A, 0);

    // Stalled consumer, then a back-to-back identical job.
    run_job(32'h6090_30C8, 32'hA0F0_7050, 8'hF3, 8'h31, 20);
    run_job(32'h6090_30C8, 32'hA0F0_7050, 8'hF3, 8'h31, 0);
    prev = exp_ones;

    // Abort during stream cycle k=100.
    submit(32'hFFFF_FFFF, 32'hFFFF_FFFF, 8'hF3, 8'h31);
    repeat (101) @(posedge clk);
    @(negedge clk);
    bus.abort = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.abort = 1'b0;
    check("abort_busy", bus.busy, 0);
    check("abort_in_ready", bus.in_ready, 1);
    check("abort_out_valid", bus.out_valid, 0);
    check("abort_ones_retained", bus.ones_count, prev);
    check("abort_result_retained", bus.result, prev * 1024);
    repeat (300) @(negedge clk);
    check("abort_no_late_result", bus.out_valid, 0);

    // Asynchronous reset pulse between edges in the middle of a run.
    submit(32'hFFFF_FFFF, 32'hFFFF_FFFF, 8'hF3, 8'h31);
    repeat (50) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("arst_in_ready", bus.in_ready, 1);
    check("arst_busy", bus.busy, 0);
    check("arst_out_valid", bus.out_valid, 0);
    check("arst_ones_count", bus.ones_count, 0);
    check("arst_result", bus.result, 0);
    #1 rst = 1'b1;
    repeat (300) @(negedge clk);
    check("arst_no_late_result", bus.out_valid, 0);

    run_job(32'hFFFF_FFFF, 32'hFFFF_FFFF, 8'h31, 8'hF3, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog_timeout actual=%0d required=%0d", checks, 0);
    $fatal(1, "simulation timed out");
  end
endmodule
